xor2_stim_checker: RTL and testbench

//  Self-checking stimulus sequencer placed directly upstream/downstream of the xor2 gate.

---
 rtl/xor2_stim_pkg.sv | 30 +++
 rtl/xor2_stim_dwell_cnt.sv | 38 +++
 rtl/xor2_stim_checker.sv | 109 ++++++++++
 tb/tb_xor2_stim_checker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/xor2_stim_pkg.sv
// Shared definitions for the xor2 stimulus checker: FSM states, the four-entry
// input vector table and the reference function for the gate under test.
package xor2_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          NUM_VEC  = 4;
    localparam logic [1:0]  LAST_VEC = 2'd3;

    // Bit i holds the value driven for vector index i: 00, 10, 01, 11 (a,b).
    localparam logic [3:0]  VEC_A = 4'b1010;
    localparam logic [3:0]  VEC_B = 4'b1100;

    function automatic logic vec_a(input logic [1:0] idx);
        return VEC_A[idx];
    endfunction

    function automatic logic vec_b(input logic [1:0] idx);
        return VEC_B[idx];
    endfunction

    function automatic logic expected_out(input logic a, input logic b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/xor2_stim_dwell_cnt.sv
// Dwell counter: counts cycles a vector has been held, flags the last one.
module xor2_stim_dwell_cnt #(
    parameter int DWELL = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(DWELL - 1));

endmodule

// File: rtl/xor2_stim_checker.sv
// Steps an xor2 gate through its four input vectors, holding each for DWELL
// cycles, and counts mismatches sampled on the last cycle of every dwell.
module xor2_stim_checker
    import xor2_stim_pkg::*;
#(
    parameter int DWELL = 20,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_out,
    output logic             a,
    output logic             b,
    output logic [1:0]       vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
);

    state_e           state_q, state_d;
    logic [1:0]       vec_idx_q, vec_idx_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             dwell_end;

    xor2_stim_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (dwell_end)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        vec_idx_d = vec_idx_q;
        err_cnt_d = err_cnt_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    vec_idx_d = '0;
                    err_cnt_d = '0;
                    cnt_clr   = 1'b1;
                end
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (dwell_end) begin
                    cnt_clr = 1'b1;
                    // The idx3 mismatch lands in err_cnt on the same edge that
                    // enters DONE, so pass sees the final count.
                    if ((dut_out != expected_out(vec_a(vec_idx_q), vec_b(vec_idx_q)))
                        && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    if (vec_idx_q == LAST_VEC) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_idx_d = vec_idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        a_d = vec_a(vec_idx_d);
        b_d = vec_b(vec_idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vec_idx_q <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            vec_idx_q <= vec_idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign vec_idx = vec_idx_q;
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign pass    = (state_q == ST_DONE) && (err_cnt_q == '0);
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_xor2_stim_checker.sv
// Randomized bench for xor2_stim_checker against a cycle-count reference model.
module tb_xor2_stim_checker;

    localparam int DWELL   = 4;
    localparam int ERR_W   = 2;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
    localparam int RUN_LEN = 4 * DWELL;

    localparam int M_GOOD   = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_INV    = 2;
    localparam int M_RAND   = 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             dut_out;
    logic             a;
    logic             b;
    logic [1:0]       vec_idx;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;

    xor2_stim_checker #(
        .DWELL (DWELL),
        .ERR_W (ERR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .dut_out (dut_out),
        .a       (a),
        .b       (b),
        .vec_idx (vec_idx),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = M_GOOD;

    int tbl_a [4] = '{0, 1, 0, 1};
    int tbl_b [4] = '{0, 0, 1, 1};

    // Reference model: cycles elapsed since the start edge, error total, run state.
    bit m_running;
    bit m_done;
    int m_n;
    int m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_running = 0;
        m_done    = 0;
        m_n       = 0;
        m_err     = 0;
    endtask

    function automatic int model_idx();
        if (m_running) return m_n / DWELL;
        return m_done ? 3 : 0;
    endfunction

    task automatic model_edge();
        int i;
        if (!rst_n) begin
            model_reset();
        end else if (m_running) begin
            m_n++;
            if (m_n % DWELL == 0) begin
                i = m_n / DWELL - 1;
                if (int'(dut_out) != (tbl_a[i] ^ tbl_b[i]) && m_err < ERR_MAX) m_err++;
                if (m_n == RUN_LEN) begin
                    m_running = 0;
                    m_done    = 1;
                end
            end
        end else if (start) begin
            m_running = 1;
            m_done    = 0;
            m_n       = 0;
            m_err     = 0;
        end
    endtask

    task automatic compare_all();
        int idx;
        idx = model_idx();
        check("a",       a,       tbl_a[idx]);
        check("b",       b,       tbl_b[idx]);
        check("vec_idx", vec_idx, idx);
        check("busy",    busy,    m_running);
        check("done",    done,    m_done);
        check("pass",    pass,    m_done && m_err == 0);
        check("err_cnt", err_cnt, m_err);
    endtask

    // Gate behaviour is only meaningful on the sampling cycle; elsewhere drive noise.
    function automatic logic pick_dut_out();
        int idx;
        int exp;
        if (!(rst_n && m_running && ((m_n + 1) % DWELL == 0)))
            return 1'($urandom_range(0, 1));
        idx = m_n / DWELL;
        exp = tbl_a[idx] ^ tbl_b[idx];
        case (mode)
            M_GOOD:   return 1'(exp);
            M_STUCK0: return 1'b0;
            M_INV:    return 1'(1 - exp);
            default:  return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic cycle(input logic st, input logic rn = 1'b1);
        @(negedge clk);
        rst_n   = rn;
        start   = st;
        dut_out = pick_dut_out();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic full_run(input int m, input int start_pulse_at);
        mode = m;
        cycle(1'b1);
        for (int k = 1; k <= RUN_LEN + 1; k++) cycle(k == start_pulse_at);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b1;
        dut_out = 1'b0;
        model_reset();

        // Reset held with start asserted: nothing moves.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0);

        // Good gate, with a start pulse mid-run that must be ignored.
        full_run(M_GOOD, 5);
        check("good_pass", pass, 1'b1);
        // Restart from DONE with stuck-at-0: two mismatches.
        full_run(M_STUCK0, 0);
        check("stuck0_err", err_cnt, 2);
        // Inverted gate: four mismatches saturate a 2-bit counter.
        full_run(M_INV, 0);
        check("inv_err_sat", err_cnt, ERR_MAX);
        // Restart clears the count on the start edge.
        mode = M_GOOD;
        cycle(1'b1);
        check("restart_clr", err_cnt, 0);

        // Asynchronous reset between edges, mid-run.
        for (int k = 0; k < 5; k++) cycle(1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        for (int k = 0; k < 2; k++) cycle(1'b1, 1'b0);
        for (int k = 0; k < RUN_LEN + 4; k++) cycle(1'b0);
        check("idle_after_rst", done, 1'b0);

        // Randomized runs: random gate behaviour and sporadic start requests.
        for (int r = 0; r < 12; r++) begin
            mode = int'($urandom_range(0, 3));
            cycle(1'b1);
            for (int k = 0; k < RUN_LEN + int'($urandom_range(0, 6)); k++)
                cycle($urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
